// File: rtl/apu_pulse_pkg.sv
// Shared constants for the pulse channel bank: length counter lookup,
// duty waveforms and register offsets within a channel's 4-byte window.
package apu_pulse_pkg;

  localparam logic [1:0] REG_CTRL  = 2'd0;  // duty / halt / constvol / volume
  localparam logic [1:0] REG_SWEEP = 2'd1;  // sweep enable / period / negate / shift
  localparam logic [1:0] REG_TLO   = 2'd2;  // timer period low byte
  localparam logic [1:0] REG_THI   = 2'd3;  // timer period high bits + length index

  localparam logic [7:0] LENGTH_TABLE [32] = '{
    8'd10,  8'd254, 8'd20,  8'd2,   8'd40,  8'd4,   8'd80,  8'd6,
    8'd160, 8'd8,   8'd60,  8'd10,  8'd14,  8'd12,  8'd26,  8'd14,
    8'd12,  8'd16,  8'd24,  8'd18,  8'd48,  8'd20,  8'd96,  8'd22,
    8'd192, 8'd24,  8'd72,  8'd26,  8'd16,  8'd28,  8'd32,  8'd30
  };

  // Bit n of each entry is the output level for sequencer step n.
  localparam logic [7:0] DUTY_TABLE [4] = '{
    8'b0100_0000, 8'b0110_0000, 8'b0111_1000, 8'b1001_1111
  };

endpackage

// File: rtl/apu_pulse_bank_if.sv
// APU register write bus shared by all pulse channels.
interface apu_pulse_bank_if #(
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] apu_addr;
  logic [7:0]        data_in;
  logic              apu_wr;

  modport master (output apu_addr, data_in, apu_wr);
  modport slave  (input  apu_addr, data_in, apu_wr);
endinterface

// File: rtl/apu_pulse_ch.sv
// One NES-style pulse channel: timer + 8-step duty sequencer, envelope,
// sweep unit and length counter. The register write has already been
// decoded to this channel; level is the combinational output sample.
module apu_pulse_ch
  import apu_pulse_pkg::*;
#(
  parameter bit ONES_COMP = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       apu_cycle,
  input  logic       qtrframe,
  input  logic       halfframe,
  input  logic       en,
  input  logic       wr,
  input  logic [1:0] reg_sel,
  input  logic [7:0] data,
  output logic       active,
  output logic [3:0] level
);

  logic [1:0]  duty_reg;
  logic        halt_reg;
  logic        constvol_reg;
  logic [3:0]  vol_reg;
  logic        sweep_en_reg;
  logic [2:0]  sweep_period_reg;
  logic        negate_reg;
  logic [2:0]  shift_reg;
  logic [10:0] period_reg;
  logic [10:0] timer_reg;
  logic [2:0]  step_reg;
  logic        env_start_reg;
  logic [3:0]  decay_reg;
  logic [3:0]  env_div_reg;
  logic        sweep_reload_reg;
  logic [2:0]  sweep_div_reg;
  logic [7:0]  length_reg;

  logic        wr_ctrl, wr_sweep, wr_tlo, wr_thi;
  logic [11:0] change, target;
  logic        muted, sweep_apply, duty_bit;
  logic [7:0]  duty_pattern;

  assign wr_ctrl  = wr && (reg_sel == REG_CTRL);
  assign wr_sweep = wr && (reg_sel == REG_SWEEP);
  assign wr_tlo   = wr && (reg_sel == REG_TLO);
  assign wr_thi   = wr && (reg_sel == REG_THI);

  // Sweep target and mute; negate never mutes even if the 12-bit result wraps
  always_comb begin
    change = {1'b0, period_reg} >> shift_reg;
    if (negate_reg)
      target = {1'b0, period_reg} - change - {11'd0, ONES_COMP};
    else
      target = {1'b0, period_reg} + change;
    muted        = (period_reg < 11'd8) || (!negate_reg && (target > 12'h7FF));
    sweep_apply  = halfframe && (sweep_div_reg == 3'd0) && sweep_en_reg &&
                   (shift_reg != 3'd0) && !muted;
    duty_pattern = DUTY_TABLE[duty_reg];
    duty_bit     = duty_pattern[step_reg];
  end

  // Control and sweep configuration fields
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_reg         <= '0;
      halt_reg         <= 1'b0;
      constvol_reg     <= 1'b0;
      vol_reg          <= '0;
      sweep_en_reg     <= 1'b0;
      sweep_period_reg <= '0;
      negate_reg       <= 1'b0;
      shift_reg        <= '0;
    end else begin
      if (wr_ctrl)
        {duty_reg, halt_reg, constvol_reg, vol_reg} <= data;
      if (wr_sweep)
        {sweep_en_reg, sweep_period_reg, negate_reg, shift_reg} <= data;
    end
  end

  // Timer period: CPU writes win over a same-cycle sweep update
  always_ff @(posedge clk) begin
    if (rst)
      period_reg <= '0;
    else if (wr_tlo)
      period_reg <= {period_reg[10:8], data};
    else if (wr_thi)
      period_reg <= {data[2:0], period_reg[7:0]};
    else if (sweep_apply)
      period_reg <= target[10:0];
  end

  // Timer counts down on APU cycles; each expiry steps the sequencer backwards
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_reg <= '0;
      step_reg  <= '0;
    end else begin
      if (apu_cycle) begin
        if (timer_reg == 11'd0) begin
          timer_reg <= period_reg;
          step_reg  <= step_reg - 3'd1;
        end else begin
          timer_reg <= timer_reg - 11'd1;
        end
      end
      if (wr_thi)
        step_reg <= 3'd0;
    end
  end

  // Sweep divider and its reload flag, clocked by half-frames
  always_ff @(posedge clk) begin
    if (rst) begin
      sweep_div_reg    <= '0;
      sweep_reload_reg <= 1'b0;
    end else begin
      if (halfframe) begin
        if ((sweep_div_reg == 3'd0) || sweep_reload_reg) begin
          sweep_div_reg    <= sweep_period_reg;
          sweep_reload_reg <= 1'b0;
        end else begin
          sweep_div_reg <= sweep_div_reg - 3'd1;
        end
      end
      if (wr_sweep)
        sweep_reload_reg <= 1'b1;
    end
  end

  // Envelope divider and decay level, clocked by quarter-frames
  always_ff @(posedge clk) begin
    if (rst) begin
      env_start_reg <= 1'b0;
      decay_reg     <= '0;
      env_div_reg   <= '0;
    end else begin
      if (qtrframe) begin
        if (env_start_reg) begin
          env_start_reg <= 1'b0;
          decay_reg     <= 4'd15;
          env_div_reg   <= vol_reg;
        end else if (env_div_reg == 4'd0) begin
          env_div_reg <= vol_reg;
          if (decay_reg != 4'd0)
            decay_reg <= decay_reg - 4'd1;
          else if (halt_reg)
            decay_reg <= 4'd15;
        end else begin
          env_div_reg <= env_div_reg - 4'd1;
        end
      end
      if (wr_thi)
        env_start_reg <= 1'b1;
    end
  end

  // Length counter: disable clears, a load beats a same-cycle decrement
  always_ff @(posedge clk) begin
    if (rst || !en)
      length_reg <= '0;
    else if (wr_thi)
      length_reg <= LENGTH_TABLE[data[7:3]];
    else if (halfframe && (length_reg != 8'd0) && !halt_reg)
      length_reg <= length_reg - 8'd1;
  end

  assign active = (length_reg != 8'd0);

  // Output level from the current state; the bank registers it
  always_comb begin
    level = 4'd0;
    if ((length_reg != 8'd0) && !muted && duty_bit)
      level = constvol_reg ? vol_reg : decay_reg;
  end

endmodule

// File: rtl/apu_pulse_bank.sv
// Bank of NUM_CH pulse channels on the shared APU register bus.
// Channel i decodes BASE_ADDR+4*i .. BASE_ADDR+4*i+3. Samples are
// registered one cycle after channel state. Optional macro
// APU_PULSE_SUM_EN builds a registered sum of all samples; without it
// sample_sum is tied to zero.
module apu_pulse_bank
  import apu_pulse_pkg::*;
#(
  parameter int         NUM_CH         = 2,
  parameter int         ADDR_W         = 5,
  parameter int         BASE_ADDR      = 0,
  parameter logic [7:0] ONES_COMP_MASK = 8'h01
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             apu_cycle,
  input  logic                             qtrframe,
  input  logic                             halfframe,
  input  logic [NUM_CH-1:0]                en,
  apu_pulse_bank_if.slave                  bus,
  output logic [NUM_CH-1:0]                active,
  output logic [4*NUM_CH-1:0]              sample,
  output logic [4+$clog2(NUM_CH+1)-1:0]    sample_sum
);

  localparam int SUM_W = 4 + $clog2(NUM_CH + 1);

  logic [31:0]         addr_ext;
  logic [4*NUM_CH-1:0] level_w;
  logic [4*NUM_CH-1:0] sample_reg;

  assign addr_ext = 32'(bus.apu_addr);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    localparam logic [31:0] CH_BASE = 32'(BASE_ADDR + 4 * gi);
    logic       hit;
    logic [1:0] reg_sel;

    assign hit     = bus.apu_wr && (addr_ext >= CH_BASE) && (addr_ext < CH_BASE + 32'd4);
    assign reg_sel = 2'(addr_ext - CH_BASE);

    apu_pulse_ch #(
      .ONES_COMP (ONES_COMP_MASK[gi])
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .apu_cycle (apu_cycle),
      .qtrframe  (qtrframe),
      .halfframe (halfframe),
      .en        (en[gi]),
      .wr        (hit),
      .reg_sel   (reg_sel),
      .data      (bus.data_in),
      .active    (active[gi]),
      .level     (level_w[4*gi +: 4])
    );
  end

  // Register all channel levels together so the mixer sees one aligned word
  always_ff @(posedge clk) begin
    if (rst)
      sample_reg <= '0;
    else
      sample_reg <= level_w;
  end

  assign sample = sample_reg;

`ifdef APU_PULSE_SUM_EN
  logic [SUM_W-1:0] sum_next, sum_reg;

  // Sum the same levels that feed sample so both update together
  always_comb begin
    sum_next = '0;
    for (int i = 0; i < NUM_CH; i++)
      sum_next = sum_next + SUM_W'(level_w[4*i +: 4]);
  end

  // Registered sum, aligned with sample
  always_ff @(posedge clk) begin
    if (rst)
      sum_reg <= '0;
    else
      sum_reg <= sum_next;
  end

  assign sample_sum = sum_reg;
`else
  assign sample_sum = '0;
`endif

endmodule

// File: tb/tb_apu_pulse_bank.sv
// Bench for apu_pulse_bank (NUM_CH=2): a per-channel rule model checks
// active/sample/sample_sum every cycle, a length table drives directed
// vectors, and hand sequences cover duty, sweep, envelope and sum cases.
module tb_apu_pulse_bank;

  localparam int NUM_CH = 2;
  localparam int SUM_W  = 4 + $clog2(NUM_CH + 1);

  logic                clk = 1'b0;
  logic                rst, apu_cycle, qtrframe, halfframe;
  logic [NUM_CH-1:0]   en;
  logic [NUM_CH-1:0]   active;
  logic [4*NUM_CH-1:0] sample;
  logic [SUM_W-1:0]    sample_sum;

  apu_pulse_bank_if #(.ADDR_W(5)) bus ();

  apu_pulse_bank #(
    .NUM_CH(NUM_CH), .ADDR_W(5), .BASE_ADDR(0), .ONES_COMP_MASK(8'h01)
  ) dut (
    .clk(clk), .rst(rst), .apu_cycle(apu_cycle), .qtrframe(qtrframe),
    .halfframe(halfframe), .en(en), .bus(bus), .active(active),
    .sample(sample), .sample_sum(sample_sum)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  int len_tab[32] = '{10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,
                      12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30};
  int duty_pat[4] = '{'h40, 'h60, 'h78, 'h9F};
  int m_ones[NUM_CH] = '{1, 0};

  // model state, one entry per channel
  int m_duty[NUM_CH], m_halt[NUM_CH], m_cv[NUM_CH], m_vol[NUM_CH];
  int m_sen[NUM_CH], m_sp[NUM_CH], m_neg[NUM_CH], m_shift[NUM_CH];
  int m_per[NUM_CH], m_timer[NUM_CH], m_step[NUM_CH];
  int m_estart[NUM_CH], m_decay[NUM_CH], m_ediv[NUM_CH];
  int m_reload[NUM_CH], m_sdiv[NUM_CH], m_len[NUM_CH];
  int exp_lvl[NUM_CH];

  typedef struct {
    int idx;
    int halt;
    int coincide;
    int n_hf;
    int exp_active;
  } len_vec_t;
  len_vec_t vecs[13];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_sum();
    int s;
    s = 0;
`ifdef APU_PULSE_SUM_EN
    for (int c = 0; c < NUM_CH; c++) s += exp_lvl[c];
`endif
    return s;
  endfunction

  task automatic clear_ch(input int c);
    m_duty[c] = 0; m_halt[c] = 0; m_cv[c] = 0; m_vol[c] = 0;
    m_sen[c] = 0; m_sp[c] = 0; m_neg[c] = 0; m_shift[c] = 0;
    m_per[c] = 0; m_timer[c] = 0; m_step[c] = 0;
    m_estart[c] = 0; m_decay[c] = 0; m_ediv[c] = 0;
    m_reload[c] = 0; m_sdiv[c] = 0; m_len[c] = 0;
  endtask

  // Advance the model across one clock edge using the inputs now applied.
  task automatic model_step();
    for (int c = 0; c < NUM_CH; c++) begin
      int chg, tgt, mute, fire, hit, off, d, per_old, a;
      chg  = m_per[c] >> m_shift[c];
      tgt  = (m_neg[c] != 0) ? m_per[c] - chg - m_ones[c] : m_per[c] + chg;
      mute = (m_per[c] < 8 || (m_neg[c] == 0 && tgt > 2047)) ? 1 : 0;
      if (m_len[c] == 0 || mute != 0 || ((duty_pat[m_duty[c]] >> m_step[c]) & 1) == 0)
        exp_lvl[c] = 0;
      else
        exp_lvl[c] = (m_cv[c] != 0) ? m_vol[c] : m_decay[c];
      if (rst) begin
        exp_lvl[c] = 0;
        clear_ch(c);
      end else begin
        a    = int'(bus.apu_addr);
        hit  = (bus.apu_wr && (a / 4 == c)) ? 1 : 0;
        off  = a % 4;
        d    = int'(bus.data_in);
        fire = (halfframe && m_sdiv[c] == 0 && m_sen[c] != 0 && m_shift[c] != 0 && mute == 0) ? 1 : 0;
        per_old = m_per[c];
        if (apu_cycle) begin
          if (m_timer[c] == 0) begin
            m_timer[c] = per_old;
            m_step[c]  = (m_step[c] + 7) % 8;
          end else m_timer[c]--;
        end
        if (halfframe) begin
          if (m_sdiv[c] == 0 || m_reload[c] != 0) begin
            m_sdiv[c] = m_sp[c]; m_reload[c] = 0;
          end else m_sdiv[c]--;
        end
        if (qtrframe) begin
          if (m_estart[c] != 0) begin
            m_estart[c] = 0; m_decay[c] = 15; m_ediv[c] = m_vol[c];
          end else if (m_ediv[c] == 0) begin
            m_ediv[c] = m_vol[c];
            if (m_decay[c] != 0) m_decay[c]--;
            else if (m_halt[c] != 0) m_decay[c] = 15;
          end else m_ediv[c]--;
        end
        if (!en[c]) m_len[c] = 0;
        else if (hit != 0 && off == 3) m_len[c] = len_tab[d >> 3];
        else if (halfframe && m_len[c] != 0 && m_halt[c] == 0) m_len[c]--;
        if (fire != 0) m_per[c] = tgt % 2048;
        if (hit != 0) begin
          case (off)
            0: begin
              m_duty[c] = d >> 6; m_halt[c] = (d >> 5) & 1;
              m_cv[c] = (d >> 4) & 1; m_vol[c] = d & 15;
            end
            1: begin
              m_sen[c] = d >> 7; m_sp[c] = (d >> 4) & 7;
              m_neg[c] = (d >> 3) & 1; m_shift[c] = d & 7; m_reload[c] = 1;
            end
            2: m_per[c] = (per_old & 'h700) | d;
            default: begin
              m_per[c] = (per_old & 'hFF) | ((d & 7) << 8);
              m_step[c] = 0; m_estart[c] = 1;
            end
          endcase
        end
      end
    end
  endtask

  // One clock: update model, let the edge pass, compare every output.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      check($sformatf("active%0d", c), int'(active[c]), (m_len[c] != 0) ? 1 : 0);
      check($sformatf("sample%0d", c), int'(sample[4*c +: 4]), exp_lvl[c]);
    end
    check("sample_sum", int'(sample_sum), exp_sum());
    apu_cycle = ~apu_cycle;
  endtask

  task automatic write(input int addr, input int data);
    bus.apu_wr   = 1'b1;
    bus.apu_addr = 5'(addr);
    bus.data_in  = 8'(data);
    tick();
    bus.apu_wr   = 1'b0;
  endtask

  task automatic hf_pulse();
    halfframe = 1'b1; tick(); halfframe = 1'b0;
  endtask

  task automatic qf_pulse();
    qtrframe = 1'b1; tick(); qtrframe = 1'b0; tick();
  endtask

  // Wait for a rising sample on channel c, then measure its high run in clk.
  task automatic measure_high(input int c, input string name, input int exp_run);
    int prev, cur, run;
    bit seen;
    seen = 1'b0;
    run  = 0;
    prev = int'(sample[4*c +: 4]);
    for (int n = 0; n < 4000 && !seen; n++) begin
      tick();
      cur = int'(sample[4*c +: 4]);
      if (prev == 0 && cur != 0) seen = 1'b1;
      prev = cur;
    end
    if (seen) begin
      run = 1;
      for (int n = 0; n < 4000; n++) begin
        tick();
        if (sample[4*c +: 4] == 4'd0) break;
        run++;
      end
    end
    check(name, run, exp_run);
  endtask

  initial begin
    int hi;
    vecs[0]  = '{3, 0, 0, 1, 1};
    vecs[1]  = '{3, 0, 0, 2, 0};
    vecs[2]  = '{0, 0, 0, 9, 1};
    vecs[3]  = '{0, 0, 0, 10, 0};
    vecs[4]  = '{3, 1, 0, 10, 1};
    vecs[5]  = '{5, 0, 0, 3, 1};
    vecs[6]  = '{5, 0, 0, 4, 0};
    vecs[7]  = '{3, 0, 1, 1, 1};
    vecs[8]  = '{3, 0, 1, 2, 0};
    vecs[9]  = '{1, 0, 0, 253, 1};
    vecs[10] = '{1, 0, 0, 254, 0};
    vecs[11] = '{2, 0, 1, 19, 1};
    vecs[12] = '{2, 0, 1, 20, 0};

    rst = 1'b1; apu_cycle = 1'b0; qtrframe = 1'b0; halfframe = 1'b0; en = '0;
    bus.apu_wr = 1'b0; bus.apu_addr = '0; bus.data_in = '0;
    for (int c = 0; c < NUM_CH; c++) clear_ch(c);
    // a write during reset must be ignored
    bus.apu_wr = 1'b1; bus.apu_addr = 5'd3; bus.data_in = 8'h08; en = 2'b11;
    tick();
    bus.apu_wr = 1'b0;
    tick(); tick();
    check("reset_active", int'(active), 0);
    check("reset_sample", int'(sample), 0);
    check("reset_sum", int'(sample_sum), 0);
    rst = 1'b0;

    // length counter / halt vectors on channel 0
    en = 2'b01;
    for (int v = 0; v < 13; v++) begin
      write(0, (vecs[v].halt != 0) ? 'h20 : 'h00);
      if (vecs[v].coincide != 0) halfframe = 1'b1;
      write(3, vecs[v].idx << 3);
      halfframe = 1'b0;
      for (int k = 0; k < vecs[v].n_hf; k++) hf_pulse();
      check($sformatf("len_vec%0d", v), int'(active[0]), vecs[v].exp_active);
      en = 2'b00; tick(); en = 2'b01;
    end

    // 50% duty, constant volume 15, period 0x10
    write(0, 'hBF); write(2, 'h10); write(3, 'h08);
    check("duty_active", int'(active[0]), 1);
    for (int n = 0; n < 300; n++) tick();
    hi = 0;
    for (int n = 0; n < 544; n++) begin
      tick();
      if (sample[3:0] == 4'd15) hi++;
    end
    check("duty_high_clks", hi, 272);

    // disable clears length; reg3 while disabled does not load
    en = 2'b00; tick();
    check("dis_active", int'(active[0]), 0);
    tick();
    check("dis_sample", int'(sample[3:0]), 0);
    write(3, 'h08);
    check("dis_load", int'(active[0]), 0);

    // sweep negate: ch0 0x100 -> 0x7F (one's comp), ch1 0x100 -> 0x80
    en = 2'b11;
    for (int c = 0; c < 2; c++) begin
      write(4*c + 0, 'hBF); write(4*c + 1, 'h89);
      write(4*c + 2, 'h00); write(4*c + 3, 'h09);
    end
    hf_pulse();
    tick();
    measure_high(0, "sweep_ch0_run", 4 * 128 * 2);
    measure_high(1, "sweep_ch1_run", 4 * 129 * 2);

    // sweep overflow mute on ch1: period 0x7F0, shift 1, add
    write(5, 'h81); write(6, 'hF0); write(7, 'h0F);
    hf_pulse();
    for (int n = 0; n < 20; n++) begin
      tick();
      check("mute_sample1", int'(sample[7:4]), 0);
    end
    check("mute_active1", int'(active[1]), 1);

    // envelope decay, divider period 3
    write(0, 'hC3); write(1, 'h08); write(2, 'hFF); write(3, 'h0F);
    qf_pulse();
    check("env_start", int'(sample[3:0]), 15);
    for (int k = 0; k < 4; k++) qf_pulse();
    check("env_first_dec", int'(sample[3:0]), 14);

    // envelope loop: reaching 0 wraps to 15
    write(0, 'hE0); write(3, 'h0F);
    qf_pulse();
    for (int k = 0; k < 15; k++) qf_pulse();
    check("env_zero", int'(sample[3:0]), 0);
    qf_pulse();
    check("env_loop", int'(sample[3:0]), 15);

    // both channels constant 15 with duty high -> sum
    for (int c = 0; c < 2; c++) begin
      write(4*c + 0, 'hDF); write(4*c + 1, 'h08);
      write(4*c + 2, 'hFF); write(4*c + 3, 'h0F);
    end
    tick(); tick();
    check("sum_ch0", int'(sample[3:0]), 15);
    check("sum_ch1", int'(sample[7:4]), 15);
`ifdef APU_PULSE_SUM_EN
    check("sum_value", int'(sample_sum), 30);
`else
    check("sum_value", int'(sample_sum), 0);
`endif

    // randomized traffic, including unmapped addresses and mid-run resets
    for (int n = 0; n < 4000; n++) begin
      rst          = ($urandom_range(0, 499) == 0);
      bus.apu_wr   = ($urandom_range(0, 2) == 0);
      bus.apu_addr = 5'($urandom_range(0, 11));
      bus.data_in  = 8'($urandom);
      qtrframe     = ($urandom_range(0, 15) == 0);
      halfframe    = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 63) == 0) en = en ^ 2'($urandom_range(1, 3));
      tick();
    end
    rst = 1'b0; bus.apu_wr = 1'b0; qtrframe = 1'b0; halfframe = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
